seq_addsub: RTL and testbench
=============================

// Module: seq_addsub
//
// PURPOSE
//   Parametrised multi-cycle (digit-serial) adder/subtractor, WIDTH bits, CHUNK bits per clock.
//   Successor to the 32-bit combinational adder: adds subtract mode, signed-overflow flag,
//   and valid/ready handshakes on input and output. Feeds narrow datapaths where a
//   full-width carry chain breaks timing. One operation in flight at a time.
//
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   CHUNK  8   bits processed per cycle; must divide WIDTH (else $error at elaboration)
//   NCHUNK = WIDTH/CHUNK (localparam)   number of RUN cycles per operation
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: add, 1: subtract
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   c_out      out  1      carry-out; in sub mode 1 = no borrow
//   ovf        out  1      two's-complement signed overflow
//   busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, chunk counter 0, sum=0, c_out=0, ovf=0, out_valid=0,
//     busy=0, in_ready=1. Reset mid-operation aborts it; no result emitted.
//   Arithmetic: sub=0 -> {c_out,sum} = a + b + c_in.
//     sub=1 -> {c_out,sum} = a + ~b + ~c_in (= a - b - c_in; c_out=0 means borrow).
//     ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//   FSM:
//     IDLE: in_ready=1. On in_valid&&in_ready, latch a, b (inverted if sub), carry
//       (c_in, or ~c_in if sub), clear counter -> RUN.
//     RUN: in_ready=0. Each cycle, chunk k = counter (LSB chunk first):
//       {carry, res[k*CHUNK +: CHUNK]} = a_k + b_k + carry; counter++.
//       After chunk NCHUNK-1 -> DONE. Latch c_out and ovf from the final chunk.
//     DONE: out_valid=1. sum/c_out/ovf held stable. On out_valid&&out_ready -> IDLE.
//       No accept on the same cycle as the output handshake.
//   Latency: out_valid rises NCHUNK cycles after the accepting edge.
//     Minimum spacing between accepts is NCHUNK+2 cycles.
//   Operand ports are sampled only at accept. Changes during RUN/DONE are ignored.
//     in_valid outside IDLE is not consumed.
//   sum/c_out/ovf keep the last result after the output handshake until the next DONE.
//     They are meaningful only while out_valid=1.
//   CHUNK==WIDTH: single RUN cycle, latency 1. CHUNK==1: bit-serial, latency WIDTH.
//
// TESTING (WIDTH=32, CHUNK=8 unless noted; every result checked vs a + b + c_in golden model)
//   1. a=FFFFFFFF b=00000001 cin=0 sub=0 -> sum=00000000, c_out=1, ovf=0;
//      out_valid exactly 4 cycles after accept.
//   2. a=80000000 b=80000000 cin=0 sub=0 -> sum=00000000, c_out=1, ovf=1.
//      Also a=100 b=200 cin=1 -> sum=301.
//   3. sub=1: a=5 b=10 cin=0 -> sum=FFFFFFFB, c_out=0, ovf=0.
//      a=80000000 b=1 cin=0 -> sum=7FFFFFFF, c_out=1, ovf=1.
//   4. out_ready=0 for 5 cycles in DONE -> out_valid, sum, c_out stay stable; in_ready=0.
//      Concurrent in_valid with a=1 is not consumed. out_ready=1 -> IDLE next cycle.
//   5. rst_n pulsed low in the 2nd RUN cycle -> out_valid=0, in_ready=1, sum=0 immediately.
//      Next op a=5 b=10 -> sum=0000000F.
//   6. 1000 random ops with random sub/cin and random in_valid/out_ready gaps, for
//      CHUNK=8, 1, 32 -> all match the model; accept count == result count; pass total printed.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial adder/subtractor, CHUNK bits per clock, LSB digit first.
// A single operation is in flight at a time, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one CHUNK-bit digit per cycle, chunk index in cnt_r
// DONE  | result held on sum/c_out/ovf, out_valid high until accepted
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_chunk_chk
    $error("seq_addsub: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_r;
  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   digit;
  logic             carry_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign last_chunk = (cnt_r == CW'(NCHUNK - 1));
  assign digit      = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
  // Result digits enter at the top and walk down, so after NCHUNK steps chunk 0 sits at the LSB.
  assign res_nxt    = WIDTH'({digit[CHUNK-1:0], res_r} >> CHUNK);
  assign carry_msb  = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ digit[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      res_r   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + ~c_in, so invert once here and the RUN path only ever adds.
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= c_in ^ sub;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_r     <= WIDTH'({{CHUNK{1'b0}}, a_r} >> CHUNK);
      b_r     <= WIDTH'({{CHUNK{1'b0}}, b_r} >> CHUNK);
      carry_r <= digit[CHUNK];
      res_r   <= res_nxt;
      cnt_r   <= cnt_r + 1'b1;
      if (last_chunk) begin
        sum   <= res_nxt;
        c_out <= digit[CHUNK];
        ovf   <= carry_msb ^ digit[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed table and corner sequences at CHUNK=8,
// then concurrent randomized runs at CHUNK=8, 1 and 32 against an arithmetic model.
module tb_seq_addsub;

  localparam int NV      = 9;
  localparam int N_RND   = 1000;
  localparam int RND_LIM = 70000;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic c_in;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [31:0] sum;
  logic c_out;
  logic ovf;
  logic busy;
  logic rnd_go;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Reference: {ovf, c_out, sum} from plain unsigned and signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mci, input logic ms);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] u;
    longint      sv;
    logic        ov;
    bb = ms ? ~mb : mb;
    cc = ms ? ~mci : mci;
    u  = {1'b0, ma} + {1'b0, bb} + {32'd0, cc};
    sv = longint'($signed(ma)) + longint'($signed(bb)) + longint'(cc);
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {ov, u};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tci,
                       input logic ts, output logic [33:0] res, output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tbv; c_in = tci; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = {ovf, c_out, sum};
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        ci;
    logic        s;
    logic [31:0] e_sum;
    logic        e_c;
    logic        e_o;
  } vec_t;

  vec_t vt [NV];

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    logic r_rst_n, r_in_valid, r_in_ready, r_c_in, r_sub, r_out_valid, r_out_ready;
    logic r_c_out, r_ovf, r_busy, done_r;
    logic [31:0] r_a, r_b, r_sum;

    seq_addsub #(.WIDTH(32), .CHUNK(CH)) u_rdut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .c_in(r_c_in), .sub(r_sub), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .sum(r_sum), .c_out(r_c_out), .ovf(r_ovf), .busy(r_busy)
    );

    initial begin : rnd_proc
      logic [33:0] q[$];
      logic [33:0] ev;
      int n_acc;
      int n_res;
      int cyc;
      done_r = 1'b0;
      r_rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
      r_a = '0; r_b = '0; r_c_in = 1'b0; r_sub = 1'b0;
      n_acc = 0; n_res = 0; cyc = 0;
      repeat (3) @(negedge clk);
      r_rst_n = 1'b1;
      wait (rnd_go);
      while (n_res < N_RND && cyc < RND_LIM) begin
        @(negedge clk);
        cyc++;
        r_a = pick();
        r_b = pick();
        r_c_in = 1'($urandom_range(0, 1));
        r_sub = 1'($urandom_range(0, 1));
        r_in_valid = (n_acc < N_RND) && ($urandom_range(0, 3) != 0);
        r_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (r_out_valid && r_out_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rnd_chunk%0d_spurious: got result %h with no pending op", CH, r_sum);
          end else begin
            ev = q.pop_front();
            chk($sformatf("rnd_chunk%0d_result", CH), {30'd0, r_ovf, r_c_out, r_sum}, {30'd0, ev});
          end
          n_res++;
        end
        if (r_in_valid && r_in_ready) begin
          q.push_back(model(r_a, r_b, r_c_in, r_sub));
          n_acc++;
        end
      end
      r_in_valid = 1'b0;
      chk($sformatf("rnd_chunk%0d_results", CH), 64'(n_res), 64'(N_RND));
      chk($sformatf("rnd_chunk%0d_acc_vs_res", CH), 64'(n_res), 64'(n_acc));
      $display("random CHUNK=%0d: %0d results checked", CH, n_res);
      done_r = 1'b1;
    end
  end

  initial begin : main
    logic [33:0] res;
    int lat;
    int n;
    n_vec = 0; n_err = 0; rnd_go = 1'b0;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[2] = '{32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0301, 1'b0, 1'b0};
    vt[3] = '{32'h0000_0005, 32'h0000_0010, 1'b0, 1'b1, 32'hFFFF_FFF5, 1'b0, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[7] = '{32'h0000_000A, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
    vt[8] = '{32'h0000_0005, 32'h0000_000A, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vt[i].va, vt[i].vb, vt[i].ci, vt[i].s, res, lat);
      chk($sformatf("vec%0d_sum", i), res[31:0], vt[i].e_sum);
      chk($sformatf("vec%0d_c_out", i), res[32], vt[i].e_c);
      chk($sformatf("vec%0d_ovf", i), res[33], vt[i].e_o);
      chk($sformatf("vec%0d_model", i), res, model(vt[i].va, vt[i].vb, vt[i].ci, vt[i].s));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // Backpressure in DONE: result must hold and a concurrent in_valid must be ignored.
    @(negedge clk);
    a = 32'd3; b = 32'd4; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'd1; b = 32'd1;
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_sum", sum, 32'd7);
      chk("stall_c_out", c_out, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_not_consumed", busy, 1'b0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 32'd7; b = 32'd8; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_result", 64'(n), 64'd0);
    do_op(32'd5, 32'd10, 1'b0, 1'b0, res, lat);
    chk("postrst_result", res, {2'b00, 32'h0000_000F});
    chk("postrst_latency", 64'(lat), 64'd4);

    rnd_go = 1'b1;
    n = 0;
    while (!(g_rnd[0].done_r && g_rnd[1].done_r && g_rnd[2].done_r) && n < 80000) begin
      @(negedge clk);
      n++;
    end
    if (!(g_rnd[0].done_r && g_rnd[1].done_r && g_rnd[2].done_r)) begin
      n_vec++;
      n_err++;
      $display("FAIL random_timeout: done flags %b%b%b required 111",
               g_rnd[0].done_r, g_rnd[1].done_r, g_rnd[2].done_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
